karatsuba_mul_arbiter: RTL and testbench

Shares one pipelined 256x256 rectangular Karatsuba multiplier between two requesters. Round-robin arbitration, a tag pipeline matched to the multiplier latency, and routing of each 512-bit product back to its requester through a per-requester result FIFO. Credit-based issue guarantees that no product is ever dropped. Sits between the modular-reduction front ends and the `rectKaratsuba` instance.

---
 rtl/karatsuba_mul_arbiter.sv | 145 ++++++++++++++
 tb/tb_karatsuba_mul_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_mul_arbiter.sv
// Two-requester round-robin front end for one pipelined 256x256 Karatsuba multiplier.
// Credits and tags route each product to a per-requester FWFT FIFO; KARA_ARB_CHECK_EN adds the sticky err port.
module karatsuba_mul_arbiter #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [255:0] req0_x,
    input  logic [255:0] req0_y,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [255:0] req1_x,
    input  logic [255:0] req1_y,
    output logic         mul_in_valid,
    output logic [255:0] mul_X,
    output logic [255:0] mul_Y,
    input  logic [511:0] mul_P,
    input  logic         mul_out_valid,
    output logic         rsp0_valid,
    output logic [511:0] rsp0_p,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    output logic [511:0] rsp1_p,
    input  logic         rsp1_ready
`ifdef KARA_ARB_CHECK_EN
    ,
    output logic         err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [AW:0]   OCC_FULL = (AW + 1)'(DEPTH);

    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic [1:0]       tag_hit;
    logic [1:0]       full;
    logic [1:0]       nonempty;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             rr;
    logic [CW-1:0]    cnt [2];
    logic [AW:0]      occ [2];
    logic [AW-1:0]    wr_ptr [2];
    logic [AW-1:0]    rd_ptr [2];
    logic [511:0]     mem [2][DEPTH];
    logic [LATENCY:0] tag_v;
    logic [LATENCY:0] tag_id;

    // Eligibility looks at the credit count before this cycle's pop, so a freed slot is usable next cycle.
    always_comb begin
        req_valid = {req1_valid, req0_valid};
        rsp_ready = {rsp1_ready, rsp0_ready};
        eligible  = '0;
        nonempty  = '0;
        full      = '0;
        tag_hit   = '0;
        for (int i = 0; i < 2; i++) begin
            eligible[i] = req_valid[i] && (cnt[i] < CNT_MAX) && !reset;
            nonempty[i] = (occ[i] != '0);
            full[i]     = (occ[i] == OCC_FULL);
            tag_hit[i]  = mul_out_valid && tag_v[LATENCY] && (tag_id[LATENCY] == 1'(i));
        end
        grant[0] = eligible[0] && (!eligible[1] || !rr);
        grant[1] = eligible[1] && (!eligible[0] || rr);
        push     = tag_hit & ~full;
        pop      = nonempty & rsp_ready;
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = nonempty[0];
    assign rsp1_valid = nonempty[1];
    assign rsp0_p     = nonempty[0] ? mem[0][rd_ptr[0]] : '0;
    assign rsp1_p     = nonempty[1] ? mem[1][rd_ptr[1]] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr           <= 1'b0;
            mul_in_valid <= 1'b0;
            mul_X        <= '0;
            mul_Y        <= '0;
            tag_v        <= '0;
            tag_id       <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i]    <= '0;
                occ[i]    <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            if (eligible[0] && eligible[1]) begin
                rr <= ~rr;
            end
            mul_in_valid <= |grant;
            if (grant[0]) begin
                mul_X <= req0_x;
                mul_Y <= req0_y;
            end else if (grant[1]) begin
                mul_X <= req1_x;
                mul_Y <= req1_y;
            end
            // Stage 0 travels with mul_in_valid; stage LATENCY lines up with mul_out_valid.
            tag_v  <= {tag_v[LATENCY-1:0], |grant};
            tag_id <= {tag_id[LATENCY-1:0], grant[1]};
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= cnt[i] + CW'(grant[i]) - CW'(pop[i]);
                occ[i] <= occ[i] + (AW + 1)'(push[i]) - (AW + 1)'(pop[i]);
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= mul_P;
            end
        end
    end

`ifdef KARA_ARB_CHECK_EN
    // Sticky: strobe/tag disagreement or a push into a full FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((mul_out_valid != tag_v[LATENCY]) || (|(tag_hit & full))) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_karatsuba_mul_arbiter.sv
// Directed bench for karatsuba_mul_arbiter with a behavioural LATENCY-cycle multiplier.
// The err checks run only when KARA_ARB_CHECK_EN is defined.
module tb_karatsuba_mul_arbiter;

    localparam int LATENCY = 3;
    localparam int DEPTH   = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [255:0] req0_x, req0_y, req1_x, req1_y;
    logic         mul_in_valid;
    logic [255:0] mul_X, mul_Y;
    logic [511:0] mul_P;
    logic         mul_out_valid;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [511:0] rsp0_p, rsp1_p;
`ifdef KARA_ARB_CHECK_EN
    logic         err;
`endif

    int total = 0;
    int bad   = 0;
    int n0    = 0;
    int n1    = 0;
    logic spurious = 1'b0;

    logic [LATENCY-1:0] ml_v;
    logic [511:0]       ml_p [LATENCY];
    logic [255:0]       ones = '1;
    logic [511:0]       exp_sq = 512'd0 - (512'd1 << 257) + 512'd1;
    logic [511:0]       exp0 [3] = '{512'd7, 512'd48 + 512'd71, 512'd351};
    logic [511:0]       exp1 [3] = '{512'd48, 512'd220, 512'd512};

    always #5 clock = ~clock;

    karatsuba_mul_arbiter #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .mul_in_valid(mul_in_valid), .mul_X(mul_X), .mul_Y(mul_Y),
        .mul_P(mul_P), .mul_out_valid(mul_out_valid),
        .rsp0_valid(rsp0_valid), .rsp0_p(rsp0_p), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_p(rsp1_p), .rsp1_ready(rsp1_ready)
`ifdef KARA_ARB_CHECK_EN
        , .err(err)
`endif
    );

    // Stand-in multiplier sharing the arbiter's reset.
    always @(posedge clock) begin
        if (reset) begin
            ml_v <= '0;
            for (int k = 0; k < LATENCY; k++) ml_p[k] <= '0;
        end else begin
            ml_v[0] <= mul_in_valid;
            ml_p[0] <= {256'd0, mul_X} * {256'd0, mul_Y};
            for (int k = 1; k < LATENCY; k++) begin
                ml_v[k] <= ml_v[k-1];
                ml_p[k] <= ml_p[k-1];
            end
        end
    end
    assign mul_out_valid = ml_v[LATENCY-1] | spurious;
    assign mul_P         = ml_p[LATENCY-1];

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic sampleOut();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic v0, input logic [255:0] x0, input logic [255:0] y0,
                                 input logic v1, input logic [255:0] x1, input logic [255:0] y1);
        req0_valid = v0; req0_x = x0; req0_y = y0;
        req1_valid = v1; req1_x = x1; req1_y = y1;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic collectRsp();
        if (rsp0_valid) begin
            checkOutput("contend_rsp0", rsp0_p, (n0 < 3) ? exp0[n0] : 512'd0);
            n0++;
        end
        if (rsp1_valid) begin
            checkOutput("contend_rsp1", rsp1_p, (n1 < 3) ? exp1[n1] : 512'd0);
            n1++;
        end
    endtask

    initial begin
        int j0, j1, i0, i1, seen;
        logic e0;
        reset = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        applyStimulus(1'b1, ones, ones, 1'b1, ones, ones);
        repeat (2) nextCycle();
        sampleOut();
        checkOutput("reset_req0_ready", 512'(req0_ready), 512'd0);
        checkOutput("reset_req1_ready", 512'(req1_ready), 512'd0);
        checkOutput("reset_mul_in_valid", 512'(mul_in_valid), 512'd0);
        checkOutput("reset_mul_X", 512'(mul_X), 512'd0);
        checkOutput("reset_rsp_valid", 512'({rsp1_valid, rsp0_valid}), 512'd0);
        checkOutput("reset_rsp0_p", rsp0_p, 512'd0);
`ifdef KARA_ARB_CHECK_EN
        checkOutput("reset_err", 512'(err), 512'd0);
`endif

        // Single request of all-ones operands.
        nextCycle();
        reset = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        nextCycle();
        applyStimulus(1'b1, ones, ones, 1'b0, '0, '0);
        sampleOut();
        checkOutput("single_req0_ready", 512'(req0_ready), 512'd1);
        checkOutput("single_req1_ready", 512'(req1_ready), 512'd0);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        sampleOut();
        checkOutput("single_mul_in_valid", 512'(mul_in_valid), 512'd1);
        checkOutput("single_mul_X", 512'(mul_X), 512'(ones));
        repeat (3) nextCycle();
        sampleOut();
        checkOutput("single_rsp_early", 512'(rsp0_valid), 512'd0);
        nextCycle();
        sampleOut();
        checkOutput("single_rsp_valid", 512'(rsp0_valid), 512'd1);
        checkOutput("single_rsp_p", rsp0_p, exp_sq);
        nextCycle();
        sampleOut();
        checkOutput("single_rsp_popped", 512'(rsp0_valid), 512'd0);

        // Contention: six cycles of both requesters valid.
        j0 = 0;
        j1 = 0;
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            i0 = 2 * j0;
            i1 = 2 * j1 + 1;
            applyStimulus(1'b1, 256'(i0 * 3 + 1), 256'(i0 * 5 + 7),
                          1'b1, 256'(i1 * 3 + 1), 256'(i1 * 5 + 7));
            sampleOut();
            e0 = ((c % 2) == 0);
            checkOutput("contend_ready0", 512'(req0_ready), 512'(e0));
            checkOutput("contend_ready1", 512'(req1_ready), 512'(!e0));
            collectRsp();
            if (e0) j0++;
            else j1++;
        end
        for (int c = 0; c < 12; c++) begin
            nextCycle();
            applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
            sampleOut();
            collectRsp();
        end
        checkOutput("contend_count0", 512'(n0), 512'd3);
        checkOutput("contend_count1", 512'(n1), 512'd3);

        // Backpressure: consumer 0 stalled.
        rsp0_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            nextCycle();
            applyStimulus(1'b1, 256'(10 + c), 256'd3, 1'b0, '0, '0);
            sampleOut();
            checkOutput("bp_ready", 512'(req0_ready), 512'(c < 4));
        end
        nextCycle();
        rsp0_ready = 1'b1;
        applyStimulus(1'b1, 256'd20, 256'd3, 1'b0, '0, '0);
        sampleOut();
        checkOutput("bp_pop_cycle_ready", 512'(req0_ready), 512'd0);
        checkOutput("bp_pop_valid", 512'(rsp0_valid), 512'd1);
        checkOutput("bp_pop_p", rsp0_p, 512'd30);
        nextCycle();
        rsp0_ready = 1'b0;
        sampleOut();
        checkOutput("bp_one_more", 512'(req0_ready), 512'd1);
        for (int c = 0; c < 3; c++) begin
            nextCycle();
            sampleOut();
            checkOutput("bp_full_again", 512'(req0_ready), 512'd0);
        end

        // Accept and pop together at DEPTH-1 credits.
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        rsp0_ready = 1'b1;
        sampleOut();
        checkOutput("simul_pop_p", rsp0_p, 512'd33);
        nextCycle();
        applyStimulus(1'b1, 256'd30, 256'd3, 1'b0, '0, '0);
        sampleOut();
        checkOutput("simul_accept", 512'(req0_ready), 512'd1);
        checkOutput("simul_pop_p2", rsp0_p, 512'd36);
        nextCycle();
        rsp0_ready = 1'b0;
        applyStimulus(1'b1, 256'd40, 256'd3, 1'b0, '0, '0);
        sampleOut();
        checkOutput("simul_next_eligible", 512'(req0_ready), 512'd1);
        nextCycle();
        sampleOut();
        checkOutput("simul_then_full", 512'(req0_ready), 512'd0);

        // Reset with three products in flight.
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        rsp0_ready = 1'b1;
        repeat (12) nextCycle();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 256'(5 + c), 256'd5, 1'b0, '0, '0);
            sampleOut();
            checkOutput("rst_pre_accept", 512'(req0_ready), 512'd1);
            nextCycle();
        end
        reset = 1'b1;
        applyStimulus(1'b1, 256'd1, 256'd1, 1'b0, '0, '0);
        sampleOut();
        checkOutput("rst_ready_low", 512'(req0_ready), 512'd0);
        nextCycle();
        reset = 1'b0;
        rsp0_ready = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            sampleOut();
            seen += int'(rsp0_valid) + int'(rsp1_valid);
            nextCycle();
        end
        checkOutput("rst_no_rsp", 512'(seen), 512'd0);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 256'd9, 256'd7, 1'b0, '0, '0);
            sampleOut();
            checkOutput("rst_credit_ready", 512'(req0_ready), 512'(c < 4));
            if (c == 4) checkOutput("rst_lat_early", 512'(rsp0_valid), 512'd0);
            if (c == 5) begin
                checkOutput("rst_lat_valid", 512'(rsp0_valid), 512'd1);
                checkOutput("rst_lat_p", rsp0_p, 512'd63);
            end
            nextCycle();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

`ifdef KARA_ARB_CHECK_EN
        repeat (6) nextCycle();
        sampleOut();
        checkOutput("err_clean", 512'(err), 512'd0);
        nextCycle();
        spurious = 1'b1;
        nextCycle();
        spurious = 1'b0;
        sampleOut();
        checkOutput("err_set", 512'(err), 512'd1);
        repeat (3) nextCycle();
        sampleOut();
        checkOutput("err_sticky", 512'(err), 512'd1);
        nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        sampleOut();
        checkOutput("err_cleared", 512'(err), 512'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
